// File: rtl/apuf_pkg.sv
// Shared constants and FSM state type for the arbiter-PUF CRP sequencer.
package apuf_pkg;

  localparam int unsigned NSTAGE = 64;

  // Fibonacci taps 64,63,61,60 expressed as bit positions 63,62,60,59.
  localparam logic [63:0] LfsrTaps    = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DefaultSeed = 64'h0000_0000_ACE1_0001;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StFire,
    StWait,
    StRest,
    StDone
  } state_e;

endpackage

// File: rtl/apuf_lfsr64.sv
// 64-bit left-shifting Fibonacci LFSR used as the internal challenge source.
module apuf_lfsr64
  import apuf_pkg::*;
#(
  parameter logic [63:0] SEED = DefaultSeed
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [63:0] state
);

  logic [63:0] state_q, state_d;
  logic        fb;

  always_comb begin
    fb      = ^(state_q & LfsrTaps);
    state_d = en ? {state_q[62:0], fb} : state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/apuf_crp_sequencer.sv
// Drives one challenge onto the arbiter PUF, launches it NREP times, majority-votes the
// synchronized responses and hands the resulting CRP record out over valid/ready.
module apuf_crp_sequencer
  import apuf_pkg::*;
#(
  parameter int unsigned NREP    = 7,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter logic [63:0] SEED    = DefaultSeed
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              chal_src,
  input  logic [NSTAGE-1:0] chal_in,
  output logic              busy,
  output logic [NSTAGE-1:0] cT,
  output logic [NSTAGE-1:0] cB,
  output logic              tigSignal,
  input  logic              respReady,
  input  logic              respBit,
  output logic              crp_valid,
  input  logic              crp_ready,
  output logic [NSTAGE-1:0] crp_chal,
  output logic              crp_resp,
  output logic [3:0]        crp_ones,
  output logic              crp_err
);

  localparam logic [7:0] SettleLast  = 8'(SETTLE - 1);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  localparam logic [3:0] NRep        = 4'(NREP);
  localparam logic [3:0] Majority    = 4'(NREP >> 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [3:0]          ones_q, ones_d;
  logic [3:0]          rep_q, rep_d;
  logic                err_q, err_d;
  logic                src_q, src_d;
  logic [NSTAGE-1:0]   chal_q, chal_d;
  logic                rr_s1_q, rr_s_q, rr_q;
  logic                rb_s1_q, rb_s_q;
  logic                capture;
  logic                lfsr_en;
  logic [63:0]         lfsr_state;

  apuf_lfsr64 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (lfsr_en),
    .state (lfsr_state)
  );

  // respReady/respBit come from the PUF arbiter, asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_s1_q <= 1'b0;
      rr_s_q  <= 1'b0;
      rr_q    <= 1'b0;
      rb_s1_q <= 1'b0;
      rb_s_q  <= 1'b0;
    end else begin
      rr_s1_q <= respReady;
      rr_s_q  <= rr_s1_q;
      rr_q    <= rr_s_q;
      rb_s1_q <= respBit;
      rb_s_q  <= rb_s1_q;
    end
  end

  assign capture = rr_s_q & ~rr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ones_q  <= '0;
      rep_q   <= '0;
      err_q   <= 1'b0;
      src_q   <= 1'b0;
      chal_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
      src_q   <= src_d;
      chal_q  <= chal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    rep_d   = rep_q;
    err_d   = err_q;
    src_d   = src_q;
    chal_d  = chal_q;
    lfsr_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          chal_d  = chal_src ? lfsr_state : chal_in;
          src_d   = chal_src;
          ones_d  = '0;
          rep_d   = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StFire;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StFire: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (capture) begin
          ones_d  = ones_q + {3'b000, rb_s_q};
          rep_d   = rep_q + 4'd1;
          cnt_d   = '0;
          state_d = StRest;
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRest: begin
        // Settle time only starts counting once the PUF has dropped respReady.
        if (rr_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = (rep_q < NRep) ? StFire : StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        if (crp_ready) begin
          lfsr_en = src_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    tigSignal = (state_q == StFire) || (state_q == StWait);
    crp_valid = (state_q == StDone);
  end

  assign cT       = chal_q;
  assign cB       = chal_q;
  assign crp_chal = chal_q;
  assign crp_ones = ones_q;
  assign crp_err  = err_q;
  assign crp_resp = (ones_q > Majority) & ~err_q;

endmodule
